// File: rtl/ps2_key_encoder_if.sv
// Key event bus from the PS/2 front end to the core's key-mapping logic.
// master drives events, slave consumes them.
interface ps2_key_encoder_if;
  logic [10:0] ps2_key;
  logic        key_stb;
  logic        frame_err;

  modport master (
    output ps2_key,
    output key_stb,
    output frame_err
  );

  modport slave (
    input ps2_key,
    input key_stb,
    input frame_err
  );
endinterface

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: synchronises and filters the raw lines, deframes scancodes,
// folds E0/F0 prefixes into flags and emits toggle-strobed key events.
module ps2_key_encoder #(
  parameter int unsigned FILTER    = 8,
  parameter int unsigned TIMEOUT   = 50000,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ps2_clk,
  input  logic                ps2_dat,
  ps2_key_encoder_if.master   evt
);

  localparam int unsigned FW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]    s1_q, s2_q, filt_q, filt_d;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [TIMEOUT_W-1:0]   to_q, to_d;
  logic [10:0]            key_q, key_d;
  logic                   stb_q, stb_d;
  logic                   err_q, err_d;

  logic fall;
  logic dat;
  logic timeout;
  logic frame_ok;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      s1_q   <= {ps2_dat, ps2_clk};
      s2_q   <= s1_q;
      filt_q <= filt_d;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= fcnt_d[i];
    end
  end

  // A level is accepted only after FILTER consecutive cycles disagreeing with the old one.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (s2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER - 1)) filt_d[i] = s2_q[i];
        else                              fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  assign fall     = filt_q[0] & ~filt_d[0];
  assign dat      = filt_q[1];
  assign timeout  = (state_q != StIdle) && !fall && (to_q == TIMEOUT_W'(TIMEOUT - 1));
  assign frame_ok = dat && ((^shift_q) ^ par_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      to_q      <= '0;
      key_q     <= '0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      to_q      <= to_d;
      key_q     <= key_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    to_d      = to_q;
    key_d     = key_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;

    if (state_q == StIdle || fall)        to_d = '0;
    else if (to_q != TIMEOUT_W'(TIMEOUT)) to_d = to_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (fall && !dat) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = dat;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (!frame_ok) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
            stb_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d = StIdle;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      to_d    = '0;
    end
  end

  assign evt.ps2_key   = key_q;
  assign evt.key_stb   = stb_q;
  assign evt.frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: frames are bit-banged on the raw PS/2 lines and
// the resulting key events are compared against hand-computed values.
module tb_ps2_key_encoder;

  localparam int unsigned TO = 1000;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_key_encoder_if bus ();

  ps2_key_encoder #(
    .FILTER   (8),
    .TIMEOUT  (TO),
    .TIMEOUT_W(16)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .evt    (bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  bit both_seen = 1'b0;

  always @(negedge clk_sys) begin
    if (bus.key_stb)   stb_cnt++;
    if (bus.frame_err) err_cnt++;
    if (bus.key_stb && bus.frame_err) both_seen = 1'b1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(12);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(5);
    end else begin
      wait_cyc(10);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b) ^ bad_par;
    bits = {1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch && (i == 4));
    ps2_dat = 1'b1;
    wait_cyc(15);
  endtask

  task automatic send_partial(input int n);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(i[0], 1'b0);
    ps2_dat = 1'b1;
  endtask

  task automatic chk_key(input string name, input logic [10:0] exp);
    checks++;
    if (bus.ps2_key !== exp) begin
      errors++;
      $display("FAIL %s: ps2_key=%h expected %h", name, bus.ps2_key, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: count=%0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wait_cyc(5);
    chk_key("reset_key", 11'h000);
    checks++;
    if ({bus.key_stb, bus.frame_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pulses: stb/err=%b expected 00", {bus.key_stb, bus.frame_err});
    end
    reset_n = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_basic;
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    chk_key("make_1c", 11'h61C);
    chk_cnt("make_1c_stb", stb_cnt - s0, 1);
    chk_cnt("make_1c_err", err_cnt - e0, 0);
  endtask

  task automatic test_break;
    int s0;
    s0 = stb_cnt;
    send_frame(8'hF0, 1'b0, 1'b0);
    chk_cnt("f0_no_stb", stb_cnt - s0, 0);
    chk_key("f0_holds", 11'h61C);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk_key("break_1c", 11'h01C);
    chk_cnt("break_1c_stb", stb_cnt - s0, 1);
  endtask

  task automatic test_extended;
    int s0;
    s0 = stb_cnt;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk_key("ext_make_75", 11'h775);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk_key("ext_break_75", 11'h175);
    chk_cnt("ext_stb_total", stb_cnt - s0, 2);
  endtask

  task automatic test_bad_parity;
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk_cnt("badpar_err", err_cnt - e0, 1);
    chk_cnt("badpar_no_stb", stb_cnt - s0, 0);
    chk_key("badpar_holds", 11'h175);
    send_frame(8'h1D, 1'b0, 1'b0);
    chk_key("after_badpar_1d", 11'h61D);
    e0 = err_cnt;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk_key("brk_cleared_by_err", 11'h21C);
    chk_cnt("brk_err_count", err_cnt - e0, 1);
  endtask

  task automatic test_timeout;
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_partial(4);
    wait_cyc(TO / 2);
    chk_cnt("timeout_not_early", err_cnt - e0, 0);
    wait_cyc(TO / 2 + 10);
    chk_cnt("timeout_err", err_cnt - e0, 1);
    chk_cnt("timeout_no_stb", stb_cnt - s0, 0);
    send_frame(8'h29, 1'b0, 1'b0);
    chk_key("after_timeout_29", 11'h629);
    chk_cnt("after_timeout_err", err_cnt - e0, 1);
  endtask

  task automatic test_glitch;
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(15);
    end
    chk_cnt("idle_glitch_err", err_cnt - e0, 0);
    chk_cnt("idle_glitch_stb", stb_cnt - s0, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk_key("glitch_frame_5a", 11'h25A);
    chk_cnt("glitch_frame_err", err_cnt - e0, 0);
    chk_cnt("glitch_frame_stb", stb_cnt - s0, 1);
  endtask

  task automatic test_reset_midframe;
    int e0;
    send_partial(3);
    #1;
    reset_n = 1'b0;
    #1;
    chk_key("async_reset_key", 11'h000);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    chk_key("post_reset_1c", 11'h61C);
    chk_cnt("post_reset_err", err_cnt - e0, 0);
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_seen) begin
      errors++;
      $display("FAIL stb_err_exclusive: both asserted=1 expected 0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_extended();
    test_bad_parity();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
